// File: rtl/pu_accum_queue_if.sv
// Processing-unit bus slot of the multi-result accumulator: command strobes and operand in,
// queue status and popped result out.
interface pu_accum_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4
);
    // Every strobe is a single-cycle command sampled on each rising edge. There is no
    // valid/ready backpressure: the scheduler consults full/empty before issuing, and a
    // command that cannot be honoured (commit on full, pop on empty) is dropped into err.
    logic                  signal_load;
    logic                  signal_init;
    logic                  signal_neg;
    logic                  signal_commit;
    logic                  signal_oe;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ATTR_WIDTH-1:0] attr_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ATTR_WIDTH-1:0] attr_out;
    logic                  full;
    logic                  empty;
    logic                  err;

    modport master (
        output signal_load, signal_init, signal_neg, signal_commit, signal_oe,
        output data_in, attr_in,
        input  data_out, attr_out, full, empty, err
    );

    modport slave (
        input  signal_load, signal_init, signal_neg, signal_commit, signal_oe,
        input  data_in, attr_in,
        output data_out, attr_out, full, empty, err
    );
endinterface

// File: rtl/pu_accum_queue.sv
// Signed accumulator with overflow detection/saturation that commits finished sums into a
// circular result queue, so accumulation of the next sum overlaps readout of earlier ones.
module pu_accum_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SIGN       = 0,
    parameter int OVERFLOW   = 1,
    parameter int DEPTH      = 4,
    parameter int SATURATE   = 0
) (
    input logic             clk,
    input logic             rst,
    pu_accum_queue_if.slave bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] MAX_VAL    = {1'b0, {MSB{1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL    = {1'b1, {MSB{1'b0}}};
    localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] acc, acc_next, op, base, sum;
    logic                  ovf, ovf_next, neg_min, add_ovf, ld_ovf;
    logic [ATTR_WIDTH-1:0] entry_attr;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ATTR_WIDTH-1:0] attr_mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  is_full, is_empty;
    logic                  pop_ok, pop_err, push_ok, push_err;

    // Only the overflow attribute bit feeds the datapath.
    logic unused_attr;
    assign unused_attr = ^bus.attr_in;

    always_comb begin
        op       = bus.signal_neg ? -bus.data_in : bus.data_in;
        neg_min  = bus.signal_neg && (bus.data_in == MIN_VAL);
        base     = bus.signal_init ? '0 : acc;
        sum      = base + op;
        add_ovf  = (base[MSB] == op[MSB]) && (sum[MSB] != base[MSB]);
        ld_ovf   = add_ovf || neg_min;
        acc_next = acc;
        ovf_next = ovf;
        if (bus.signal_load) begin
            acc_next = sum;
            // Negating the most-negative value is a positive operand that cannot be represented.
            if ((SATURATE != 0) && ld_ovf)
                acc_next = (neg_min || !op[MSB]) ? MAX_VAL : MIN_VAL;
            ovf_next = (ovf && !bus.signal_init) || ld_ovf || bus.attr_in[OVERFLOW];
        end
        entry_attr           = '0;
        entry_attr[SIGN]     = acc_next[MSB];
        entry_attr[OVERFLOW] = ovf_next;
    end

    always_comb begin
        is_full  = (count == FULL_COUNT);
        is_empty = (count == '0);
        pop_ok   = bus.signal_oe && !is_empty;
        pop_err  = bus.signal_oe && is_empty;
        // A same-cycle pop frees the slot a commit on a full queue needs; an empty queue
        // is never bypassed, so the pop fails while the push still lands.
        push_ok  = bus.signal_commit && (!is_full || pop_ok);
        push_err = bus.signal_commit && is_full && !pop_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc          <= '0;
            ovf          <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.data_out <= '0;
            bus.attr_out <= '0;
            bus.err      <= 1'b0;
        end else begin
            if (bus.signal_commit) begin
                acc <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= acc_next;
                ovf <= ovf_next;
            end
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count        <= count + CW'(push_ok) - CW'(pop_ok);
            bus.data_out <= pop_ok ? data_mem[rd_ptr] : '0;
            bus.attr_out <= pop_ok ? attr_mem[rd_ptr] : '0;
            bus.err      <= bus.err || push_err || pop_err;
        end
    end

    // Storage needs no reset: count/pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr] <= acc_next;
            attr_mem[wr_ptr] <= entry_attr;
        end
    end

    assign bus.full  = is_full;
    assign bus.empty = is_empty;
endmodule

// File: tb/tb_pu_accum_queue.sv
// Bench for pu_accum_queue: a wrap-mode and a saturating instance share one stimulus stream;
// directed vectors, a reset sequence and a randomized run against an arithmetic model.
module tb_pu_accum_queue;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pu_accum_queue_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) if_w ();
    pu_accum_queue_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) if_s ();

    assign if_s.signal_load   = if_w.signal_load;
    assign if_s.signal_init   = if_w.signal_init;
    assign if_s.signal_neg    = if_w.signal_neg;
    assign if_s.signal_commit = if_w.signal_commit;
    assign if_s.signal_oe     = if_w.signal_oe;
    assign if_s.data_in       = if_w.data_in;
    assign if_s.attr_in       = if_w.attr_in;

    pu_accum_queue #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .SIGN(0), .OVERFLOW(1),
                     .DEPTH(DEPTH), .SATURATE(0)) dut_wrap (.clk(clk), .rst(rst), .bus(if_w));
    pu_accum_queue #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .SIGN(0), .OVERFLOW(1),
                     .DEPTH(DEPTH), .SATURATE(1)) dut_sat (.clk(clk), .rst(rst), .bus(if_s));

    always #5 clk = ~clk;

    // ctl = {load, init, neg, commit, oe}; fe = {full, empty, err}
    typedef struct packed {
        logic [4:0]    ctl;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [DW-1:0] dw;
        logic [AW-1:0] aw;
        logic [DW-1:0] ds;
        logic [AW-1:0] as_;
        logic [2:0]    fe;
    } vec_t;

    vec_t tbl[31];

    // Reference model state: queue entries are {ovf_sat, data_sat, ovf_wrap, data_wrap}.
    logic [17:0]   exp_q[$];
    logic [DW-1:0] m_acc_w, m_acc_s, m_dw, m_ds;
    logic          m_ovf_w, m_ovf_s, m_err;
    logic [AW-1:0] m_aw, m_as;

    function automatic vec_t v(input logic [4:0] ctl, input logic [7:0] d, input logic [3:0] a,
                               input logic [7:0] dw, input logic [3:0] aw,
                               input logic [7:0] ds, input logic [3:0] as_, input logic [2:0] fe);
        vec_t r;
        r.ctl = ctl; r.d = d; r.a = a; r.dw = dw; r.aw = aw; r.ds = ds; r.as_ = as_; r.fe = fe;
        return r;
    endfunction

    function automatic logic [3:0] attr_of(input logic o, input logic [7:0] d);
        return {2'b00, o, d[7]};
    endfunction

    // Plain integer arithmetic: true sum, range check, then wrap or clamp.
    function automatic logic [8:0] next_sum(input logic sat, input logic [7:0] acc, input logic ovf,
                                            input logic [4:0] ctl, input logic [7:0] d,
                                            input logic ain_ovf);
        int total, op, base;
        logic o;
        logic [7:0] r;
        if (!ctl[4]) return {ovf, acc};
        base  = ctl[3] ? 0 : int'($signed(acc));
        op    = ctl[2] ? -int'($signed(d)) : int'($signed(d));
        total = base + op;
        o     = (total > 127) || (total < -128) || (ctl[2] && d == 8'h80);
        r     = total[7:0];
        if (sat && o) r = (op > 0) ? 8'h7F : 8'h80;
        return {((ovf && !ctl[3]) || o || ain_ovf), r};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_acc_w = '0; m_acc_s = '0; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
        m_dw = '0; m_ds = '0; m_aw = '0; m_as = '0; m_err = 1'b0;
    endtask

    task automatic model_cycle(input logic [4:0] ctl, input logic [7:0] d, input logic [3:0] a);
        logic [8:0]  nw, ns;
        logic [17:0] e;
        nw = next_sum(1'b0, m_acc_w, m_ovf_w, ctl, d, a[1]);
        ns = next_sum(1'b1, m_acc_s, m_ovf_s, ctl, d, a[1]);
        m_dw = '0; m_ds = '0; m_aw = '0; m_as = '0;
        if (ctl[0]) begin
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                m_dw = e[7:0];
                m_aw = attr_of(e[8], e[7:0]);
                m_ds = e[16:9];
                m_as = attr_of(e[17], e[16:9]);
            end else m_err = 1'b1;
        end
        if (ctl[1]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({ns, nw});
            else m_err = 1'b1;
            m_acc_w = '0; m_acc_s = '0; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
        end else begin
            m_acc_w = nw[7:0]; m_ovf_w = nw[8];
            m_acc_s = ns[7:0]; m_ovf_s = ns[8];
        end
    endtask

    task automatic set_in(input logic [4:0] ctl, input logic [7:0] d, input logic [3:0] a);
        if_w.signal_load   = ctl[4];
        if_w.signal_init   = ctl[3];
        if_w.signal_neg    = ctl[2];
        if_w.signal_commit = ctl[1];
        if_w.signal_oe     = ctl[0];
        if_w.data_in       = d;
        if_w.attr_in       = a;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] dw, input logic [3:0] aw,
                              input logic [7:0] ds, input logic [3:0] as_, input logic [2:0] fe);
        check({tag, " data_wrap"},  32'(if_w.data_out), 32'(dw));
        check({tag, " attr_wrap"},  32'(if_w.attr_out), 32'(aw));
        check({tag, " data_sat"},   32'(if_s.data_out), 32'(ds));
        check({tag, " attr_sat"},   32'(if_s.attr_out), 32'(as_));
        check({tag, " full_wrap"},  32'(if_w.full),     32'(fe[2]));
        check({tag, " empty_wrap"}, 32'(if_w.empty),    32'(fe[1]));
        check({tag, " err_wrap"},   32'(if_w.err),      32'(fe[0]));
        check({tag, " full_sat"},   32'(if_s.full),     32'(fe[2]));
        check({tag, " empty_sat"},  32'(if_s.empty),    32'(fe[1]));
        check({tag, " err_sat"},    32'(if_s.err),      32'(fe[0]));
    endtask

    task automatic apply_reset();
        set_in(5'b00000, 8'h00, 4'h0);
        rst = 1'b0;
        #1;
        check_outs("reset", 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = v(5'b11000, 8'h05, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        tbl[1]  = v(5'b10000, 8'h03, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        tbl[2]  = v(5'b10100, 8'h02, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        tbl[3]  = v(5'b00010, 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b000);
        tbl[4]  = v(5'b00001, 8'h00, 4'h0, 8'h06, 4'h0, 8'h06, 4'h0, 3'b010);
        tbl[5]  = v(5'b11000, 8'h64, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        tbl[6]  = v(5'b10000, 8'h32, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        tbl[7]  = v(5'b00010, 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b000);
        tbl[8]  = v(5'b00001, 8'h00, 4'h0, 8'h96, 4'h3, 8'h7F, 4'h2, 3'b010);
        tbl[9]  = v(5'b11000, 8'h0A, 4'h2, 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        tbl[10] = v(5'b10000, 8'h05, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        tbl[11] = v(5'b00010, 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b000);
        tbl[12] = v(5'b00001, 8'h00, 4'h0, 8'h0F, 4'h2, 8'h0F, 4'h2, 3'b010);
        tbl[13] = v(5'b10000, 8'h01, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        tbl[14] = v(5'b00010, 8'h00, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b000);
        tbl[15] = v(5'b00001, 8'h00, 4'h0, 8'h01, 4'h0, 8'h01, 4'h0, 3'b010);
        tbl[16] = v(5'b11010, 8'h01, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b000);
        tbl[17] = v(5'b11010, 8'h02, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b000);
        tbl[18] = v(5'b11010, 8'h03, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b000);
        tbl[19] = v(5'b11010, 8'h04, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b100);
        tbl[20] = v(5'b11011, 8'h09, 4'h0, 8'h01, 4'h0, 8'h01, 4'h0, 3'b100);
        tbl[21] = v(5'b11010, 8'h05, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b101);
        tbl[22] = v(5'b00001, 8'h00, 4'h0, 8'h02, 4'h0, 8'h02, 4'h0, 3'b001);
        tbl[23] = v(5'b00001, 8'h00, 4'h0, 8'h03, 4'h0, 8'h03, 4'h0, 3'b001);
        tbl[24] = v(5'b00001, 8'h00, 4'h0, 8'h04, 4'h0, 8'h04, 4'h0, 3'b001);
        tbl[25] = v(5'b00001, 8'h00, 4'h0, 8'h09, 4'h0, 8'h09, 4'h0, 3'b011);
        tbl[26] = v(5'b11110, 8'h80, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b001);
        tbl[27] = v(5'b00001, 8'h00, 4'h0, 8'h80, 4'h3, 8'h7F, 4'h2, 3'b011);
        tbl[28] = v(5'b11000, 8'h9C, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b011);
        tbl[29] = v(5'b10110, 8'h32, 4'h0, 8'h00, 4'h0, 8'h00, 4'h0, 3'b001);
        tbl[30] = v(5'b00001, 8'h00, 4'h0, 8'h6A, 4'h2, 8'h80, 4'h3, 3'b011);

        set_in(5'b00000, 8'h00, 4'h0);
        #2;
        apply_reset();

        for (int i = 0; i < 31; i++) begin
            set_in(tbl[i].ctl, tbl[i].d, tbl[i].a);
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].dw, tbl[i].aw, tbl[i].ds, tbl[i].as_, tbl[i].fe);
        end

        // Pop on empty, two queued entries and a live sum, then asynchronous reset.
        apply_reset();
        set_in(5'b00001, 8'h00, 4'h0);
        tick();
        check_outs("pop_empty", 8'h00, 4'h0, 8'h00, 4'h0, 3'b011);
        set_in(5'b11010, 8'h07, 4'h0);
        tick();
        set_in(5'b11010, 8'h08, 4'h0);
        tick();
        set_in(5'b10001, 8'h03, 4'h0);
        tick();
        check_outs("pre_reset", 8'h07, 4'h0, 8'h07, 4'h0, 3'b001);
        rst = 1'b0;
        #1;
        check_outs("async_reset", 8'h00, 4'h0, 8'h00, 4'h0, 3'b010);
        set_in(5'b00000, 8'h00, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        set_in(5'b10010, 8'h07, 4'h0);
        tick();
        check_outs("post_reset_commit", 8'h00, 4'h0, 8'h00, 4'h0, 3'b000);
        set_in(5'b00001, 8'h00, 4'h0);
        tick();
        check_outs("post_reset_pop", 8'h07, 4'h0, 8'h07, 4'h0, 3'b010);

        apply_reset();
        for (int i = 0; i < 600; i++) begin
            logic [4:0] ctl;
            logic [7:0] d;
            logic [3:0] a;
            ctl[4] = ($urandom_range(0, 3) != 0);
            ctl[3] = ($urandom_range(0, 3) == 0);
            ctl[2] = ($urandom_range(0, 1) == 0);
            ctl[1] = ($urandom_range(0, 2) == 0);
            ctl[0] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0:       d = 8'h80;
                    1:       d = 8'h7F;
                    2:       d = 8'hFF;
                    default: d = 8'h01;
                endcase
            end else d = 8'($urandom_range(0, 255));
            a    = 4'($urandom_range(0, 15));
            a[1] = ($urandom_range(0, 7) == 0);
            set_in(ctl, d, a);
            model_cycle(ctl, d, a);
            tick();
            check_outs($sformatf("rnd%0d", i), m_dw, m_aw, m_ds, m_as,
                       {exp_q.size() == DEPTH, exp_q.size() == 0, m_err});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
